usb_cdc_cmd_decoder: RTL
========================

// Module: usb_cdc_cmd_decoder
// PURPOSE
// - Host->device command path of the CDC device: consumes bulk OUT bytes delivered by usb_cdc and
//   drives an 8-bit output register (routed to uio/uo pins by the top level).
// - Replies over the bulk IN byte stream with ASCII status/readback characters.
// - Complements the input-event path: that path turns pins into IN characters; this block turns
//   OUT characters into pin values.
// PARAMETERS
// - RST_VAL   8'h00   value loaded into gpio_o on reset
// PORTS
// - clk         in   1  48 MHz system clock
// - rst_n       in   1  asynchronous active-low reset
// - out_data_i  in   8  byte from usb_cdc bulk OUT FIFO
// - out_valid_i in   1  out_data_i valid
// - out_ready_o out  1  block accepts out_data_i this cycle
// - in_data_o   out  8  reply byte to usb_cdc bulk IN FIFO
// - in_valid_o  out  1  in_data_o valid
// - in_ready_i  in   1  usb_cdc accepts in_data_o this cycle
// - gpio_o      out  8  command-controlled output register
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, gpio_o=RST_VAL, in_valid_o=0, in_data_o=8'h00,
//   out_ready_o=0 while in reset; partial command discarded. Mid-transfer reset drops any held reply.
// - Handshakes: OUT byte taken on clk edge with out_valid_i&out_ready_o; IN byte retired on edge
//   with in_valid_o&in_ready_i. in_data_o stable while in_valid_o=1 and not yet accepted.
// - out_ready_o=1 only in IDLE and ARG; 0 in all reply states (one transaction in flight).
// - FSM states: IDLE, ARG, RESP, RHEX_HI, RHEX_LO (+ECHO when macro set).
//   IDLE: 'S'/'C'/'T' (8'h53/43/54) -> latch opcode, ARG. 'R' (8'h52) -> latch gpio_o into snapshot,
//     RHEX_HI. 8'h0D, 8'h0A, 8'h20 -> ignored, stay IDLE, no reply. Any other byte (incl. lowercase)
//     -> RESP with '?' (8'h3F).
//   ARG: '0'..'7' (8'h30..8'h37) -> apply op to bit n, RESP with 'K' (8'h4B). Any other byte
//     (incl. '8','9', CR) -> gpio_o unchanged, RESP with '?'.
//   Ops: S sets bit n, C clears bit n, T inverts bit n. gpio_o changes on the same edge that
//     accepts the digit byte; in_valid_o rises on that same edge (1-cycle latency).
//   RESP: hold reply until in_ready_i, then IDLE.
//   RHEX_HI/LO: send snapshot[7:4] then [3:0] as uppercase ASCII hex ('0'-'9' = 8'h30+, 'A'-'F'
//     = 8'h41+); each waits for in_ready_i; after LO -> IDLE. Snapshot is gpio_o at 'R' acceptance.
// - in_ready_i asserted while in_valid_o=0 has no effect. out_valid_i while out_ready_o=0 is
//   back-pressured, never dropped.
// - in_ready_i held low indefinitely: block stalls in reply state, gpio_o holds.
// - No counters wrap; bit index always 3 bits from out_data_i[2:0] after range check.
// CONFIGURATION
// - USB_CMD_ECHO_EN defined: every accepted non-ignored byte is first echoed unchanged via ECHO
//   state (in_valid_o rises on accepting edge, out_ready_o=0 until echo retired), then the normal
//   transition of IDLE/ARG is taken; replies follow echo. Ignored CR/LF/space are not echoed.
// - Undefined: no ECHO state; only 'K', '?' and hex replies are ever sent.
// TESTING
// - Reset RST_VAL=8'h00; send "S3" -> gpio_o=8'h08 on digit-accept edge; IN stream = 'K'.
// - From 8'h08 send "T3","T0","C7" -> gpio_o 8'h00, 8'h01, 8'h01; IN stream "KKK".
// - Set gpio_o=8'hA5 via S/C; send 'R' -> IN stream "A5" (8'h41,8'h35), gpio_o unchanged.
// - Send "S9", then 'x' -> gpio_o unchanged, IN stream "??"; send "\r\n " -> no IN bytes.
// - Hold in_ready_i=0 for 50 cycles after "S1": in_valid_o=1, in_data_o=8'h4B stable,
//   out_ready_o=0, next OUT byte not consumed; release -> 'K' retired, next byte accepted.
// - Assert rst_n=0 while in ARG after 'S' and while holding a reply -> in_valid_o=0, gpio_o=RST_VAL
//   immediately; after release "S2" yields 8'h04. With USB_CMD_ECHO_EN: "S2" -> IN "S2K".

Source files
------------

// File: rtl/usb_cdc_cmd_decoder.sv
// Bulk OUT command decoder: S/C/T<digit> drive gpio_o bits, R reads gpio_o back as two hex chars.
// Optional USB_CMD_ECHO_EN: every accepted non-ignored byte is echoed before its reply.
module usb_cdc_cmd_decoder #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic [7:0] gpio_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARG     = 3'd1;
  localparam logic [2:0] RESP    = 3'd2;
  localparam logic [2:0] RHEX_HI = 3'd3;
  localparam logic [2:0] RHEX_LO = 3'd4;
`ifdef USB_CMD_ECHO_EN
  localparam logic [2:0] ECHO    = 3'd5;
`endif

  localparam logic [1:0] OP_SET = 2'd0;
  localparam logic [1:0] OP_CLR = 2'd1;
  localparam logic [1:0] OP_TGL = 2'd2;

  logic [2:0] state, nxt_state;
  logic [1:0] op, nxt_op;
  logic [7:0] snap, nxt_snap, nxt_gpio, nxt_reply;
  logic       out_fire, in_fire, reply_now;

`ifdef USB_CMD_ECHO_EN
  logic [2:0] pend_state;
  logic [7:0] pend_reply;
  logic       pend_valid;
  logic       ignored;
  assign ignored = (state == IDLE) &&
                   (out_data_i == 8'h0D || out_data_i == 8'h0A || out_data_i == 8'h20);
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign out_ready_o = rst_n && (state == IDLE || state == ARG);
  assign out_fire    = out_valid_i && out_ready_o;
  assign in_fire     = in_valid_o && in_ready_i;
  assign reply_now   = (nxt_state == RESP) || (nxt_state == RHEX_HI);

  always_comb begin
    nxt_state = state;
    nxt_op    = op;
    nxt_snap  = snap;
    nxt_gpio  = gpio_o;
    nxt_reply = '0;
    case (state)
      IDLE: begin
        case (out_data_i)
          8'h53: begin nxt_op = OP_SET; nxt_state = ARG; end
          8'h43: begin nxt_op = OP_CLR; nxt_state = ARG; end
          8'h54: begin nxt_op = OP_TGL; nxt_state = ARG; end
          8'h52: begin
            nxt_snap  = gpio_o;
            nxt_reply = hex_char(gpio_o[7:4]);
            nxt_state = RHEX_HI;
          end
          8'h0D, 8'h0A, 8'h20: ;
          default: begin nxt_reply = 8'h3F; nxt_state = RESP; end
        endcase
      end
      ARG: begin
        nxt_state = RESP;
        // '0'..'7' are exactly the bytes 0011_0xxx
        if (out_data_i[7:3] == 5'b00110) begin
          nxt_reply = 8'h4B;
          case (op)
            OP_SET:  nxt_gpio[out_data_i[2:0]] = 1'b1;
            OP_CLR:  nxt_gpio[out_data_i[2:0]] = 1'b0;
            default: nxt_gpio[out_data_i[2:0]] = ~gpio_o[out_data_i[2:0]];
          endcase
        end else begin
          nxt_reply = 8'h3F;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= OP_SET;
      snap       <= '0;
      gpio_o     <= RST_VAL;
      in_valid_o <= 1'b0;
      in_data_o  <= '0;
`ifdef USB_CMD_ECHO_EN
      pend_state <= IDLE;
      pend_reply <= '0;
      pend_valid <= 1'b0;
`endif
    end else if (out_fire) begin
      gpio_o <= nxt_gpio;
      op     <= nxt_op;
      snap   <= nxt_snap;
`ifdef USB_CMD_ECHO_EN
      // Park the decoded transition until the echo byte is retired.
      if (!ignored) begin
        state      <= ECHO;
        pend_state <= nxt_state;
        pend_reply <= nxt_reply;
        pend_valid <= reply_now;
        in_valid_o <= 1'b1;
        in_data_o  <= out_data_i;
      end
`else
      state      <= nxt_state;
      in_valid_o <= reply_now;
      in_data_o  <= nxt_reply;
`endif
    end else if (in_fire) begin
      case (state)
`ifdef USB_CMD_ECHO_EN
        ECHO: begin
          state      <= pend_state;
          in_valid_o <= pend_valid;
          in_data_o  <= pend_reply;
        end
`endif
        RHEX_HI: begin
          state     <= RHEX_LO;
          in_data_o <= hex_char(snap[3:0]);
        end
        default: begin
          state      <= IDLE;
          in_valid_o <= 1'b0;
          in_data_o  <= '0;
        end
      endcase
    end
  end

endmodule
